// File: rtl/flappy_pkg.sv
// Shared types and helpers for the Flappy VGA compositor.
package flappy_pkg;

    localparam int COORD_W = 10;
    localparam logic [7:0] TRANSPARENT = 8'hFF;

    // Widest packed slot bus the helper accepts (8 slots x 16-bit coordinates).
    localparam int SLOT_BUS_W = 128;

    // Layer codes carried down the pixel pipeline.
    typedef enum logic [1:0] {
        LAYER_NONE = 2'd0,
        LAYER_CAT  = 2'd1,
        LAYER_PIPE = 2'd2,
        LAYER_COIN = 2'd3
    } layer_t;

    // Returns slot idx of a packed bus (slot 0 in the LSBs) in the low bits;
    // the caller truncates the result to its field width.
    function automatic logic [SLOT_BUS_W-1:0] slot_field(
        input logic [SLOT_BUS_W-1:0] bus,
        input int unsigned           idx,
        input int unsigned           width
    );
        return bus >> (idx * width);
    endfunction

endpackage

// File: rtl/coin_vis_reg.sv
// Coin visibility mask: init clears it, otherwise a collect clears one bit
// of the current mask and a shift then advances the slots, refilling the
// top slot with a visible coin.
module coin_vis_reg #(
    parameter int NUM_SLOTS = 5,
    parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic                 clk_vga,
    input  logic                 rst,
    input  logic                 vis_init,
    input  logic                 vis_shift,
    input  logic                 collect_valid,
    input  logic [IDX_W-1:0]     collect_idx,
    output logic [NUM_SLOTS-1:0] coin_vis
);

    logic [NUM_SLOTS-1:0] v_col;
    logic [NUM_SLOTS-1:0] v_next;

    // Next mask: collect on the pre-shift mask, then the optional shift.
    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        v_col = coin_vis;
        if (collect_valid && (int'(collect_idx) < NUM_SLOTS)) begin
            v_col[collect_idx] = 1'b0;
        end
        v_next = v_col;
        if (vis_shift) begin
            v_next = {1'b1, v_col[NUM_SLOTS-1:1]};
        end
    end

    // Mask register; init overrides collect and shift.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            coin_vis <= '0;
        end else if (vis_init) begin
            coin_vis <= '0;
        end else begin
            coin_vis <= v_next;
        end
    end

endmodule

// File: rtl/sprite_layer_mixer.sv
// Per-pixel sprite compositor: cat over pipes over coins, with geometric
// ROM addressing, a 3-edge pipeline matched to 1-cycle synchronous ROMs,
// and per-frame collision / coin-hit reporting.
module sprite_layer_mixer #(
    parameter int               NUM_SLOTS   = 5,
    parameter int               COORD_W     = flappy_pkg::COORD_W,
    parameter int               RGB_W       = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = flappy_pkg::TRANSPARENT,
    parameter int               CAT_W       = 32,
    parameter int               PIPE_W      = 64,
    parameter int               PIPE_H      = 32,
    parameter int               COIN_W      = 32,
    parameter int               COIN_H      = 21
) (
    input  logic                                 clk_vga,
    input  logic                                 rst,
    input  logic [COORD_W-1:0]                   x_ptr,
    input  logic [COORD_W-1:0]                   y_ptr,
    input  logic                                 frame_sync,
    input  logic [COORD_W-1:0]                   cat_xl,
    input  logic [COORD_W-1:0]                   cat_xr,
    input  logic [COORD_W-1:0]                   cat_yt,
    input  logic [COORD_W-1:0]                   cat_yb,
    input  logic [NUM_SLOTS*COORD_W-1:0]         pipe_xl,
    input  logic [NUM_SLOTS*COORD_W-1:0]         pipe_xr,
    input  logic [NUM_SLOTS*COORD_W-1:0]         pipe_gap_t,
    input  logic [NUM_SLOTS*COORD_W-1:0]         pipe_gap_b,
    input  logic [NUM_SLOTS*COORD_W-1:0]         coin_xl,
    input  logic [NUM_SLOTS*COORD_W-1:0]         coin_y,
    input  logic                                 vis_init,
    input  logic                                 vis_shift,
    input  logic                                 collect_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0]         collect_idx,
    output logic [$clog2(CAT_W)+COORD_W-1:0]     addr_cat,
    output logic [$clog2(PIPE_W*PIPE_H)-1:0]     addr_pipe,
    output logic [$clog2(COIN_W)+5-1:0]          addr_coin,
    input  logic [RGB_W-1:0]                     data_cat,
    input  logic [RGB_W-1:0]                     data_pipe,
    input  logic [RGB_W-1:0]                     data_coin,
    output logic [RGB_W-1:0]                     RGB,
    output logic [NUM_SLOTS-1:0]                 coin_vis,
    output logic                                 collide,
    output logic [NUM_SLOTS-1:0]                 coin_hit
);

    import flappy_pkg::*;

    localparam int CAT_SH  = $clog2(CAT_W);
    localparam int CAT_AW  = CAT_SH + COORD_W;
    localparam int PW_B    = $clog2(PIPE_W);
    localparam int PH_B    = $clog2(PIPE_H);
    localparam int COIN_SH = $clog2(COIN_W);
    localparam int COIN_AW = COIN_SH + 5;

    // Unpacked per-slot geometry.
    logic [COORD_W-1:0] p_xl [NUM_SLOTS];
    logic [COORD_W-1:0] p_xr [NUM_SLOTS];
    logic [COORD_W-1:0] p_gt [NUM_SLOTS];
    logic [COORD_W-1:0] p_gb [NUM_SLOTS];
    logic [COORD_W-1:0] c_xl [NUM_SLOTS];
    logic [COORD_W-1:0] c_y  [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign p_xl[g] = COORD_W'(slot_field(SLOT_BUS_W'(pipe_xl),    g, COORD_W));
        assign p_xr[g] = COORD_W'(slot_field(SLOT_BUS_W'(pipe_xr),    g, COORD_W));
        assign p_gt[g] = COORD_W'(slot_field(SLOT_BUS_W'(pipe_gap_t), g, COORD_W));
        assign p_gb[g] = COORD_W'(slot_field(SLOT_BUS_W'(pipe_gap_b), g, COORD_W));
        assign c_xl[g] = COORD_W'(slot_field(SLOT_BUS_W'(coin_xl),    g, COORD_W));
        assign c_y[g]  = COORD_W'(slot_field(SLOT_BUS_W'(coin_y),     g, COORD_W));
    end

    coin_vis_reg #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_coin_vis (
        .clk_vga       (clk_vga),
        .rst           (rst),
        .vis_init      (vis_init),
        .vis_shift     (vis_shift),
        .collect_valid (collect_valid),
        .collect_idx   (collect_idx),
        .coin_vis      (coin_vis)
    );

    logic                 cat_on;
    logic [COORD_W-1:0]   cat_dx;
    logic [COORD_W-1:0]   cat_dy;
    logic [CAT_AW-1:0]    cat_addr_d;
    logic [NUM_SLOTS-1:0] pipe_on;
    logic [NUM_SLOTS-1:0] coin_on;
    logic [COORD_W-1:0]   c_dx [NUM_SLOTS];
    logic [COORD_W-1:0]   c_dy [NUM_SLOTS];
    logic                 pipe_any;
    logic [PW_B-1:0]      pipe_dx;
    logic                 coin_any;
    logic [COORD_W-1:0]   coin_dx;
    logic [COORD_W-1:0]   coin_dy;
    logic [COIN_AW-1:0]   coin_addr_d;
    layer_t               layer_d;
    layer_t               layer_s1;
    layer_t               layer_s2;
    logic [RGB_W-1:0]     rgb_d;
    logic                 col_s;
    logic [NUM_SLOTS-1:0] hit_s;
    logic                 col_now;
    logic [NUM_SLOTS-1:0] hit_now;

    // Cat hit test and its ROM address (only used when cat_on).
    always_comb begin
        cat_on     = (x_ptr >= cat_xl) && (x_ptr <= cat_xr) &&
                     (y_ptr >= cat_yt) && (y_ptr <= cat_yb);
        cat_dx     = x_ptr - cat_xl;
        cat_dy     = y_ptr - cat_yt;
        cat_addr_d = (CAT_AW'(cat_dy) << CAT_SH) + CAT_AW'(cat_dx);
    end

    // Per-slot pipe and coin hit tests; coin bounds are checked as offsets
    // so that xl+COIN_W-1 can never wrap.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            c_dx[i]    = x_ptr - c_xl[i];
            c_dy[i]    = y_ptr - c_y[i];
            pipe_on[i] = (x_ptr >= p_xl[i]) && (x_ptr <= p_xr[i]) &&
                         ((y_ptr <= p_gt[i]) || (y_ptr >= p_gb[i]));
            coin_on[i] = coin_vis[i] &&
                         (x_ptr >= c_xl[i]) && (c_dx[i] < COORD_W'(COIN_W)) &&
                         (y_ptr >= c_y[i])  && (c_dy[i] < COORD_W'(COIN_H));
        end
    end

    // Lowest-index slot wins: scan downwards so the last match is the lowest.
    always_comb begin
        pipe_any = 1'b0;
        pipe_dx  = '0;
        coin_any = 1'b0;
        coin_dx  = '0;
        coin_dy  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pipe_on[i]) begin
                pipe_any = 1'b1;
                pipe_dx  = PW_B'(x_ptr - p_xl[i]);
            end
            if (coin_on[i]) begin
                coin_any = 1'b1;
                coin_dx  = c_dx[i];
                coin_dy  = c_dy[i];
            end
        end
        coin_addr_d = (COIN_AW'(coin_dy) << COIN_SH) + COIN_AW'(coin_dx);
    end

    // Layer priority for the current pixel: CAT > PIPE > COIN > NONE.
    always_comb begin
        layer_d = LAYER_NONE;
        if (cat_on) begin
            layer_d = LAYER_CAT;
        end else if (pipe_any) begin
            layer_d = LAYER_PIPE;
        end else if (coin_any) begin
            layer_d = LAYER_COIN;
        end
    end

    // Edges E0/E1: register addresses of active layers, then walk the layer
    // code alongside the ROM latency.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            addr_cat  <= '0;
            addr_pipe <= '0;
            addr_coin <= '0;
            layer_s1  <= LAYER_NONE;
            layer_s2  <= LAYER_NONE;
        end else begin
            if (cat_on) begin
                addr_cat <= cat_addr_d;
            end
            if (pipe_any) begin
                addr_pipe <= {y_ptr[PH_B-1:0], pipe_dx};
            end
            if (coin_any) begin
                addr_coin <= coin_addr_d;
            end
            layer_s1 <= layer_d;
            layer_s2 <= layer_s1;
        end
    end

    // Pick the ROM word for the stage-2 layer; the colour key blanks it.
    always_comb begin
        case (layer_s2)
            LAYER_CAT:  rgb_d = data_cat;
            LAYER_PIPE: rgb_d = data_pipe;
            LAYER_COIN: rgb_d = data_coin;
            default:    rgb_d = '0;
        endcase
        if (rgb_d == TRANSPARENT) begin
            rgb_d = '0;
        end
    end

    // Edge E2: composited pixel out.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            RGB <= '0;
        end else begin
            RGB <= rgb_d;
        end
    end

    assign col_now = cat_on && pipe_any;
    assign hit_now = {NUM_SLOTS{cat_on}} & coin_on;

    // Sticky per-frame flags; the frame_sync pixel is folded into the report.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            col_s    <= 1'b0;
            hit_s    <= '0;
            collide  <= 1'b0;
            coin_hit <= '0;
        end else if (frame_sync) begin
            collide  <= col_s | col_now;
            coin_hit <= hit_s | hit_now;
            col_s    <= 1'b0;
            hit_s    <= '0;
        end else begin
            col_s <= col_s | col_now;
            hit_s <= hit_s | hit_now;
        end
    end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed bench for sprite_layer_mixer: inputs driven and outputs checked
// on the falling clock edge, expected values worked out by hand.
module tb_sprite_layer_mixer;

    localparam int NUM_SLOTS = 5;
    localparam int COORD_W   = 10;
    localparam int RGB_W     = 8;
    localparam int IDX_W     = 3;
    localparam int CAT_AW    = 15;
    localparam int PIPE_AW   = 11;
    localparam int COIN_AW   = 10;

    logic                         clk_vga;
    logic                         rst;
    logic [COORD_W-1:0]           x_ptr, y_ptr;
    logic                         frame_sync;
    logic [COORD_W-1:0]           cat_xl, cat_xr, cat_yt, cat_yb;
    logic [NUM_SLOTS*COORD_W-1:0] pipe_xl, pipe_xr, pipe_gap_t, pipe_gap_b;
    logic [NUM_SLOTS*COORD_W-1:0] coin_xl, coin_y;
    logic                         vis_init, vis_shift, collect_valid;
    logic [IDX_W-1:0]             collect_idx;
    logic [CAT_AW-1:0]            addr_cat;
    logic [PIPE_AW-1:0]           addr_pipe;
    logic [COIN_AW-1:0]           addr_coin;
    logic [RGB_W-1:0]             data_cat, data_pipe, data_coin;
    logic [RGB_W-1:0]             RGB;
    logic [NUM_SLOTS-1:0]         coin_vis;
    logic                         collide;
    logic [NUM_SLOTS-1:0]         coin_hit;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_layer_mixer dut (
        .clk_vga       (clk_vga),
        .rst           (rst),
        .x_ptr         (x_ptr),
        .y_ptr         (y_ptr),
        .frame_sync    (frame_sync),
        .cat_xl        (cat_xl),
        .cat_xr        (cat_xr),
        .cat_yt        (cat_yt),
        .cat_yb        (cat_yb),
        .pipe_xl       (pipe_xl),
        .pipe_xr       (pipe_xr),
        .pipe_gap_t    (pipe_gap_t),
        .pipe_gap_b    (pipe_gap_b),
        .coin_xl       (coin_xl),
        .coin_y        (coin_y),
        .vis_init      (vis_init),
        .vis_shift     (vis_shift),
        .collect_valid (collect_valid),
        .collect_idx   (collect_idx),
        .addr_cat      (addr_cat),
        .addr_pipe     (addr_pipe),
        .addr_coin     (addr_coin),
        .data_cat      (data_cat),
        .data_pipe     (data_pipe),
        .data_coin     (data_coin),
        .RGB           (RGB),
        .coin_vis      (coin_vis),
        .collide       (collide),
        .coin_hit      (coin_hit)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL timeout: sequence did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_vga);
    endtask

    task automatic set_pixel(input int x, input int y);
        x_ptr = COORD_W'(x);
        y_ptr = COORD_W'(y);
    endtask

    task automatic set_cat(input int xl, input int xr, input int yt, input int yb);
        cat_xl = COORD_W'(xl);
        cat_xr = COORD_W'(xr);
        cat_yt = COORD_W'(yt);
        cat_yb = COORD_W'(yb);
    endtask

    task automatic set_pipe(input int s, input int xl, input int xr, input int gt, input int gb);
        pipe_xl[s*COORD_W +: COORD_W]    = COORD_W'(xl);
        pipe_xr[s*COORD_W +: COORD_W]    = COORD_W'(xr);
        pipe_gap_t[s*COORD_W +: COORD_W] = COORD_W'(gt);
        pipe_gap_b[s*COORD_W +: COORD_W] = COORD_W'(gb);
    endtask

    task automatic set_coin(input int s, input int xl, input int y);
        coin_xl[s*COORD_W +: COORD_W] = COORD_W'(xl);
        coin_y[s*COORD_W +: COORD_W]  = COORD_W'(y);
    endtask

    task automatic frame_pulse();
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
    endtask

    initial begin
        // Quiet defaults: every sprite parked where the test pixels never go.
        rst           = 1'b1;
        frame_sync    = 1'b0;
        vis_init      = 1'b0;
        vis_shift     = 1'b0;
        collect_valid = 1'b0;
        collect_idx   = '0;
        data_cat      = '0;
        data_pipe     = '0;
        data_coin     = '0;
        set_pixel(0, 0);
        set_cat(1023, 0, 1023, 0);
        for (int s = 0; s < NUM_SLOTS; s++) begin
            set_pipe(s, 1023, 0, 0, 1023);
            set_coin(s, 1000, 1000);
        end
        tick(2);

        // Reset state
        check("rst_addr_cat",  32'(addr_cat),  32'd0);
        check("rst_addr_pipe", 32'(addr_pipe), 32'd0);
        check("rst_addr_coin", 32'(addr_coin), 32'd0);
        check("rst_rgb",       32'(RGB),       32'd0);
        check("rst_coin_vis",  32'(coin_vis),  32'd0);
        check("rst_collide",   32'(collide),   32'd0);
        check("rst_coin_hit",  32'(coin_hit),  32'd0);
        rst = 1'b0;
        tick(1);

        // Cat pixel (101,202) in box 100..131 x 200..231
        set_cat(100, 131, 200, 231);
        set_pixel(101, 202);
        data_cat = 8'h3C;
        tick(1);
        check("cat_addr", 32'(addr_cat), 32'd65);
        tick(2);
        check("cat_rgb", 32'(RGB), 32'h3C);
        data_cat = 8'hFF;
        tick(1);
        check("cat_transparent", 32'(RGB), 32'h0);

        // Pipe slot 2: 300..363, gap 150..250
        set_pipe(2, 300, 363, 150, 250);
        set_pixel(310, 40);
        data_pipe = 8'h5A;
        tick(1);
        check("pipe_addr", 32'(addr_pipe), 32'd522);
        check("cat_addr_hold", 32'(addr_cat), 32'd65);
        tick(2);
        check("pipe_rgb", 32'(RGB), 32'h5A);

        // Slot 0 overlapping slot 2 takes priority: (8*64)+5
        set_pipe(0, 305, 320, 150, 250);
        tick(1);
        check("pipe_low_slot_addr", 32'(addr_pipe), 32'd517);
        set_pipe(0, 1023, 0, 0, 1023);

        // Inclusive corner (xr, gap_t): 22*64+63
        set_pixel(363, 150);
        tick(1);
        check("pipe_edge_addr", 32'(addr_pipe), 32'd1471);

        // Inside the gap: nothing drawn, address held
        set_pixel(310, 200);
        tick(3);
        check("pipe_gap_rgb", 32'(RGB), 32'h0);
        check("pipe_addr_hold", 32'(addr_pipe), 32'd1471);

        // Cat over pipe at (310,40)
        set_cat(300, 331, 40, 71);
        data_cat = 8'h3C;
        set_pixel(310, 40);
        tick(1);
        check("overlap_cat_addr", 32'(addr_cat), 32'd10);
        tick(2);
        check("overlap_rgb_cat", 32'(RGB), 32'h3C);
        set_pixel(0, 0);
        frame_pulse();
        check("collide_set", 32'(collide), 32'd1);
        check("coin_hit_none", 32'(coin_hit), 32'd0);
        frame_pulse();
        check("collide_clear", 32'(collide), 32'd0);

        // Overlap only on the frame_sync pixel still counts
        set_pixel(310, 40);
        frame_sync = 1'b1;
        tick(1);
        frame_sync = 1'b0;
        set_pixel(0, 0);
        check("collide_sync_pixel", 32'(collide), 32'd1);
        frame_pulse();
        check("collide_sync_cleared", 32'(collide), 32'd0);

        // Coin visibility: init, three shifts
        vis_init = 1'b1;
        tick(1);
        vis_init  = 1'b0;
        vis_shift = 1'b1;
        tick(3);
        vis_shift = 1'b0;
        check("vis_shift3", 32'(coin_vis), 32'b11100);
        collect_valid = 1'b1;
        collect_idx   = 3'd3;
        vis_shift     = 1'b1;
        tick(1);
        check("vis_collect_shift", 32'(coin_vis), 32'b11010);
        vis_shift   = 1'b0;
        collect_idx = 3'd5;
        tick(1);
        check("vis_idx_out_of_range", 32'(coin_vis), 32'b11010);
        vis_init    = 1'b1;
        vis_shift   = 1'b1;
        collect_idx = 3'd1;
        tick(1);
        check("vis_init_priority", 32'(coin_vis), 32'b00000);
        vis_init      = 1'b0;
        vis_shift     = 1'b0;
        collect_valid = 1'b0;

        // Coin slot 1 at (500,100), invisible; cat box 510..541 x 100..131
        set_cat(510, 541, 100, 131);
        set_coin(1, 500, 100);
        data_coin = 8'h77;
        set_pixel(505, 103);
        tick(3);
        check("coin_invisible_rgb", 32'(RGB), 32'h0);
        check("coin_invisible_addr", 32'(addr_coin), 32'd0);
        set_pixel(515, 105);
        tick(1);
        set_pixel(0, 0);
        frame_pulse();
        check("coin_hit_invisible", 32'(coin_hit), 32'd0);

        // Make slot 1 visible: four shifts from all-clear
        vis_shift = 1'b1;
        tick(4);
        vis_shift = 1'b0;
        check("vis_shift4", 32'(coin_vis), 32'b11110);
        set_pixel(505, 103);
        tick(1);
        check("coin_addr", 32'(addr_coin), 32'd101);
        tick(2);
        check("coin_rgb", 32'(RGB), 32'h77);
        set_pixel(505, 121);
        tick(3);
        check("coin_below_rgb", 32'(RGB), 32'h0);
        check("coin_addr_hold", 32'(addr_coin), 32'd101);
        set_pixel(505, 120);
        tick(1);
        check("coin_last_row_addr", 32'(addr_coin), 32'd645);
        set_pixel(515, 105);
        tick(3);
        check("cat_over_coin_rgb", 32'(RGB), 32'h3C);
        set_pixel(0, 0);
        frame_pulse();
        check("coin_hit_slot1", 32'(coin_hit), 32'b00010);
        check("coin_frame_collide", 32'(collide), 32'd0);

        // Mid-frame asynchronous reset while the cat is on a coin
        set_pixel(515, 105);
        tick(3);
        check("pre_reset_rgb", 32'(RGB), 32'h3C);
        #2;
        rst = 1'b1;
        set_pixel(0, 0);
        #1;
        check("async_rst_rgb",       32'(RGB),       32'd0);
        check("async_rst_coin_vis",  32'(coin_vis),  32'd0);
        check("async_rst_coin_hit",  32'(coin_hit),  32'd0);
        check("async_rst_addr_cat",  32'(addr_cat),  32'd0);
        check("async_rst_addr_pipe", 32'(addr_pipe), 32'd0);
        check("async_rst_addr_coin", 32'(addr_coin), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        frame_pulse();
        check("post_rst_collide",  32'(collide),  32'd0);
        check("post_rst_coin_hit", 32'(coin_hit), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
